mac_dot: RTL and testbench
==========================

MAC_DOT -- requirements
Module: mac_dot

Interface
REQ-001 The block SHALL take parameter DW, default 8, meaning operand width in bits.
REQ-002 The block SHALL take parameter AW, default 24, meaning accumulator width in bits (AW >= 2*DW).
REQ-003 The block SHALL take parameter LEN, default 4, meaning products per dot-product vector (LEN >= 1).
REQ-004 The block SHALL take parameter SGN, default 0, meaning 0 = unsigned and 1 = two's-complement operands.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port r, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a/b are accepted this cycle.
REQ-008 The block SHALL have port a, input, DW bits: multiplicand.
REQ-009 The block SHALL have port b, input, DW bits: multiplier.
REQ-010 The block SHALL have port clr, input, 1 bit: synchronous abort of the current vector.
REQ-011 The block SHALL have port acc, output, AW bits: running or final accumulated sum.
REQ-012 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse when acc holds a completed LEN-term sum.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag, set when saturation occurred in the current vector.

Function
REQ-014 Pipeline: stage 1 SHALL register a*b (2*DW bits, signed per SGN) plus a valid bit; stage 2 SHALL add the registered product into acc.
REQ-015 Latency: a pair accepted at edge t SHALL be reflected in acc after edge t+2; in_valid may be held high every cycle (throughput 1 per clock) or carry gaps of any length.
REQ-016 Product extension SHALL be zero-extension when SGN=0 and sign-extension when SGN=1.
REQ-017 The add SHALL saturate: SGN=0 clamps to 2^AW-1; SGN=1 clamps to 2^(AW-1)-1 or -2^(AW-1); any clamp SHALL set ovf.
REQ-018 An internal term counter SHALL run 0..LEN-1, incrementing on each stage-2 accumulate and wrapping to 0 after the LEN-th term.
REQ-019 FSM: IDLE -> ACC on the first stage-2 product; ACC -> DONE on the LEN-th product; DONE -> ACC if a stage-2 product is present, else DONE -> IDLE.
REQ-020 out_valid SHALL be 1 for exactly the one cycle after the LEN-th accumulate (state DONE); acc SHALL hold that sum until the next product arrives.
REQ-021 The first product of each vector SHALL load acc (not add to it) and SHALL clear ovf before applying its own saturation result.
REQ-022 LEN=1 SHALL produce out_valid for every product, and back-to-back vectors SHALL complete with no bubble.
REQ-023 clr SHALL zero acc, the counter, ovf, out_valid and the stage-1 valid bit and return the FSM to IDLE; a pair presented with clr is discarded.
REQ-024 r SHALL have priority over clr, and clr SHALL have priority over in_valid.

Reset
REQ-025 On r=1 at an edge, acc=0, ovf=0, out_valid=0, the counter=0, the stage-1 product and valid bit =0, and the FSM = IDLE.
REQ-026 Reset asserted mid-vector SHALL discard all partial terms; the first accepted pair after reset deasserts SHALL start a new vector.

Structure
REQ-027 Package mac_pkg SHALL hold the FSM state enum (IDLE, ACC, DONE) and a function giving the saturation limits from AW and SGN.
REQ-028 The saturating adder SHALL be a sub-module mac_sat_add (parameters AW and SGN; outputs sum and a clamp flag).

Verification
REQ-029 DW=8, AW=16, LEN=4, SGN=0; pairs (6,7), (5,4), (9,2), (3,8) on consecutive cycles -> out_valid pulses 2 cycles after the last pair, acc=104, ovf=0.
REQ-030 AW=16, SGN=0; four pairs of (255,255) -> acc=65535, ovf=1 at out_valid; the next vector (1,1) x4 -> acc=4, ovf=0.
REQ-031 SGN=1, AW=16; pairs (-3,5), (2,-4), (-128,-128), (7,1) -> acc=16368; a separate 4-term vector of (-128,127) x4 -> acc=-65024, which SHALL clamp to -32768 with ovf=1.
REQ-032 Same pairs as REQ-029 with in_valid low for 3 cycles between each pair -> same acc=104, and out_valid only after the 4th pair.
REQ-033 Two pairs accepted, then clr for 1 cycle, then four (1,1) pairs -> acc=4 with out_valid; the partial terms do not appear.
REQ-034 Two pairs accepted, then r for 1 cycle -> all outputs are 0 the next cycle; back-to-back vectors with LEN=1 -> out_valid high on consecutive cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the mac_dot multiply-accumulate block.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // Upper clamp value for an accumulator of width aw; the caller keeps the low aw bits.
    function automatic logic [63:0] sat_hi(input int aw, input int sgn);
        if (sgn != 0) return (64'd1 << (aw - 1)) - 64'd1;
        if (aw >= 64) return '1;
        return (64'd1 << aw) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_lo(input int aw, input int sgn);
        if (sgn != 0) return ~((64'd1 << (aw - 1)) - 64'd1);
        return '0;
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Saturating adder: clamps to the accumulator range and flags when it did.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int AW  = 24,
    parameter int SGN = 0
) (
    input  logic [AW-1:0] x,
    input  logic [AW-1:0] y,
    output logic [AW-1:0] sum,
    output logic          clamp
);

    localparam logic [AW-1:0] HI = AW'(sat_hi(AW, SGN));
    localparam logic [AW-1:0] LO = AW'(sat_lo(AW, SGN));

    logic [AW:0]        wide_u;
    logic signed [AW:0] wide_s;
    logic               over;
    logic               neg;

    assign wide_u = {1'b0, x} + {1'b0, y};
    assign wide_s = $signed({x[AW-1], x}) + $signed({y[AW-1], y});

    always_comb begin
        if (SGN != 0) begin
            over = (wide_s[AW] != wide_s[AW-1]);
            neg  = wide_s[AW];
            sum  = wide_s[AW-1:0];
        end else begin
            over = wide_u[AW];
            neg  = 1'b0;
            sum  = wide_u[AW-1:0];
        end
        clamp = over;
        if (over) sum = neg ? LO : HI;
    end

endmodule

// File: rtl/mac_dot.sv
// Two-stage pipelined dot-product MAC: registered multiply, then saturating
// accumulate over LEN terms with a one-cycle completion pulse.
module mac_dot
    import mac_pkg::*;
#(
    parameter int DW  = 8,
    parameter int AW  = 24,
    parameter int LEN = 4,
    parameter int SGN = 0
) (
    input  logic          clk,
    input  logic          r,
    input  logic          in_valid,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          clr,
    output logic [AW-1:0] acc,
    output logic          out_valid,
    output logic          ovf
);

    localparam int            CW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic signed [2*DW-1:0] prod_s;
    logic [2*DW-1:0]        prod_u;
    logic [2*DW-1:0]        prod_p1;
    logic                   vld_p1;
    logic [AW-1:0]          ext_p1;
    logic [AW-1:0]          sum;
    logic                   clamp;
    logic [CW-1:0]          cnt;
    logic                   first;
    logic                   last;
    state_t                 state;
    state_t                 state_nx;

    assign prod_s = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    assign prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    // Stage 1: register the product and its valid bit
    always_ff @(posedge clk) begin
        if (r || clr) begin
            vld_p1  <= 1'b0;
            prod_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) prod_p1 <= (SGN != 0) ? $unsigned(prod_s) : prod_u;
        end
    end

    always_comb begin
        ext_p1 = '0;
        ext_p1[2*DW-1:0] = prod_p1;
        for (int i = 2 * DW; i < AW; i++) ext_p1[i] = (SGN != 0) && prod_p1[2*DW-1];
    end

    assign first = (cnt == '0);
    assign last  = (cnt == LAST);

    // The first term of a vector loads rather than accumulates.
    mac_sat_add #(
        .AW (AW),
        .SGN(SGN)
    ) u_sat (
        .x    (first ? '0 : acc),
        .y    (ext_p1),
        .sum  (sum),
        .clamp(clamp)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vld_p1) state_nx = last ? DONE : ACC;
            ACC:     if (vld_p1 && last) state_nx = DONE;
            DONE:    state_nx = vld_p1 ? (last ? DONE : ACC) : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r || clr) state <= IDLE;
        else          state <= state_nx;
    end

    // Stage 2: saturating accumulate and term counting
    always_ff @(posedge clk) begin
        if (r || clr) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (vld_p1) begin
            acc <= sum;
            ovf <= first ? clamp : (ovf | clamp);
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_mac_dot.sv
// Directed bench for mac_dot covering unsigned, signed and LEN=1 configurations.
module tb_mac_dot;

    logic        clk = 1'b0;
    logic        r = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        clr = 1'b0;
    logic [15:0] acc_u, acc_s, acc_1;
    logic        ov_u, ov_s, ov_1;
    logic        ovf_u, ovf_s, ovf_1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mac_dot #(.DW(8), .AW(16), .LEN(4), .SGN(0)) u_uns (
        .clk(clk), .r(r), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .acc(acc_u), .out_valid(ov_u), .ovf(ovf_u)
    );

    mac_dot #(.DW(8), .AW(16), .LEN(4), .SGN(1)) u_sgn (
        .clk(clk), .r(r), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .acc(acc_s), .out_valid(ov_s), .ovf(ovf_s)
    );

    mac_dot #(.DW(8), .AW(16), .LEN(1), .SGN(0)) u_one (
        .clk(clk), .r(r), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .acc(acc_1), .out_valid(ov_1), .ovf(ovf_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        r = 1'b1;
        tick();
        r = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1;
        tick();
        tick();
        r = 1'b0;
        checks++; if (acc_u !== 16'd0) begin failures++; $display("FAIL reset_acc got=%0d want=0", acc_u); end
        checks++; if (ov_u !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", ov_u); end
        checks++; if (ovf_u !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf_u); end
        checks++; if (acc_s !== 16'd0) begin failures++; $display("FAIL reset_acc_sgn got=%0d want=0", acc_s); end
    endtask

    task automatic test_dot();
        do_reset();
        pair(8'd6, 8'd7);
        pair(8'd5, 8'd4);
        pair(8'd9, 8'd2);
        pair(8'd3, 8'd8);
        checks++; if (acc_u !== 16'd80 || ov_u !== 1'b0) begin failures++; $display("FAIL dot_partial got acc=%0d ov=%b want acc=80 ov=0", acc_u, ov_u); end
        tick();
        checks++; if (acc_u !== 16'd104) begin failures++; $display("FAIL dot_acc got=%0d want=104", acc_u); end
        checks++; if (ov_u !== 1'b1) begin failures++; $display("FAIL dot_out_valid got=%b want=1", ov_u); end
        checks++; if (ovf_u !== 1'b0) begin failures++; $display("FAIL dot_ovf got=%b want=0", ovf_u); end
        tick();
        checks++; if (ov_u !== 1'b0 || acc_u !== 16'd104) begin failures++; $display("FAIL dot_hold got acc=%0d ov=%b want acc=104 ov=0", acc_u, ov_u); end
    endtask

    task automatic test_sat_unsigned();
        do_reset();
        for (int i = 0; i < 4; i++) pair(8'd255, 8'd255);
        tick();
        checks++; if (acc_u !== 16'hFFFF || ov_u !== 1'b1) begin failures++; $display("FAIL sat_u_acc got acc=%0d ov=%b want acc=65535 ov=1", acc_u, ov_u); end
        checks++; if (ovf_u !== 1'b1) begin failures++; $display("FAIL sat_u_ovf got=%b want=1", ovf_u); end
        for (int i = 0; i < 4; i++) pair(8'd1, 8'd1);
        tick();
        checks++; if (acc_u !== 16'd4 || ov_u !== 1'b1) begin failures++; $display("FAIL sat_u_next got acc=%0d ov=%b want acc=4 ov=1", acc_u, ov_u); end
        checks++; if (ovf_u !== 1'b0) begin failures++; $display("FAIL sat_u_ovf_clear got=%b want=0", ovf_u); end
    endtask

    task automatic test_signed();
        do_reset();
        pair(8'hFD, 8'h05);
        pair(8'h02, 8'hFC);
        pair(8'h80, 8'h80);
        pair(8'h07, 8'h01);
        tick();
        checks++; if (acc_s !== 16'd16368 || ov_s !== 1'b1) begin failures++; $display("FAIL sgn_acc got acc=%0d ov=%b want acc=16368 ov=1", acc_s, ov_s); end
        checks++; if (ovf_s !== 1'b0) begin failures++; $display("FAIL sgn_ovf got=%b want=0", ovf_s); end
        for (int i = 0; i < 4; i++) pair(8'h80, 8'h7F);
        tick();
        checks++; if (acc_s !== 16'h8000 || ov_s !== 1'b1) begin failures++; $display("FAIL sgn_clamp got acc=%h ov=%b want acc=8000 ov=1", acc_s, ov_s); end
        checks++; if (ovf_s !== 1'b1) begin failures++; $display("FAIL sgn_clamp_ovf got=%b want=1", ovf_s); end
    endtask

    task automatic test_gaps();
        logic [7:0] xa [4] = '{8'd6, 8'd5, 8'd9, 8'd3};
        logic [7:0] xb [4] = '{8'd7, 8'd4, 8'd2, 8'd8};
        logic early = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pair(xa[i], xb[i]);
            if (ov_u) early = 1'b1;
            if (i < 3) begin
                for (int k = 0; k < 3; k++) begin
                    tick();
                    if (ov_u) early = 1'b1;
                end
            end
        end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL gap_early got=%b want=0", early); end
        tick();
        checks++; if (acc_u !== 16'd104 || ov_u !== 1'b1) begin failures++; $display("FAIL gap_acc got acc=%0d ov=%b want acc=104 ov=1", acc_u, ov_u); end
    endtask

    task automatic test_clr();
        do_reset();
        pair(8'd6, 8'd7);
        pair(8'd5, 8'd4);
        a = 8'd9;
        b = 8'd2;
        in_valid = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        checks++; if (acc_u !== 16'd0 || ov_u !== 1'b0) begin failures++; $display("FAIL clr_zero got acc=%0d ov=%b want acc=0 ov=0", acc_u, ov_u); end
        tick();
        checks++; if (acc_u !== 16'd0) begin failures++; $display("FAIL clr_discard got=%0d want=0", acc_u); end
        for (int i = 0; i < 4; i++) pair(8'd1, 8'd1);
        tick();
        checks++; if (acc_u !== 16'd4 || ov_u !== 1'b1) begin failures++; $display("FAIL clr_next got acc=%0d ov=%b want acc=4 ov=1", acc_u, ov_u); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pair(8'd6, 8'd7);
        pair(8'd5, 8'd4);
        r = 1'b1;
        tick();
        r = 1'b0;
        checks++; if (acc_u !== 16'd0 || ov_u !== 1'b0 || ovf_u !== 1'b0) begin failures++; $display("FAIL rst_mid got acc=%0d ov=%b ovf=%b want 0 0 0", acc_u, ov_u, ovf_u); end
        tick();
        checks++; if (acc_u !== 16'd0) begin failures++; $display("FAIL rst_discard got=%0d want=0", acc_u); end
        for (int i = 0; i < 4; i++) pair(8'd1, 8'd2);
        tick();
        checks++; if (acc_u !== 16'd8 || ov_u !== 1'b1) begin failures++; $display("FAIL rst_next got acc=%0d ov=%b want acc=8 ov=1", acc_u, ov_u); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pair(8'd3, 8'd4);
        pair(8'd5, 8'd6);
        checks++; if (acc_1 !== 16'd12 || ov_1 !== 1'b1) begin failures++; $display("FAIL len1_first got acc=%0d ov=%b want acc=12 ov=1", acc_1, ov_1); end
        pair(8'd2, 8'd2);
        checks++; if (acc_1 !== 16'd30 || ov_1 !== 1'b1) begin failures++; $display("FAIL len1_second got acc=%0d ov=%b want acc=30 ov=1", acc_1, ov_1); end
        tick();
        checks++; if (acc_1 !== 16'd4 || ov_1 !== 1'b1) begin failures++; $display("FAIL len1_third got acc=%0d ov=%b want acc=4 ov=1", acc_1, ov_1); end
        tick();
        checks++; if (acc_1 !== 16'd4 || ov_1 !== 1'b0) begin failures++; $display("FAIL len1_idle got acc=%0d ov=%b want acc=4 ov=0", acc_1, ov_1); end
    endtask

    initial begin
        test_reset();
        test_dot();
        test_sat_unsigned();
        test_signed();
        test_gaps();
        test_clr();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
